fp_normalize: RTL and testbench
===============================

Name: fp_normalize

Overview:
- Two-stage pipelined normaliser placed directly upstream of the FPU rounding stage.
- Accepts a raw significand, with one carry bit, from the add/mul datapath, along with a signed biased exponent, sign and rounding mode.
- Produces a significand with the hidden bit at the MSB, plus guard/round/sticky positions intact, and the adjusted exponent the rounder consumes.
- Handles carry-out, leading-zero shift, subnormal clamp, underflow right-shift and exponent overflow, with valid/ready backpressure.

Parameters:
- SIG_BITS, 32, output significand width; bit SIG_BITS-1 is the hidden bit.
- FRA_BITS, 23, fraction bits; carried for the rounder and not used arithmetically here.
- EXP_BITS, 8, output biased exponent width.
- FRM_BITS, 3, rounding-mode width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept
- in_sig  in  SIG_BITS+1  raw significand; bit SIG_BITS is the carry
- in_exp  in  EXP_BITS+2  signed two's-complement biased exponent for bit SIG_BITS-1
- in_sign  in  1  sign
- in_frm  in  FRM_BITS  rounding mode
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sig  out  SIG_BITS  normalised significand
- out_exp  out  EXP_BITS  biased exponent; 0 means subnormal or zero
- out_sign  out  1  passthrough
- out_frm  out  FRM_BITS  passthrough
- out_of  out  1  exponent overflow

Behaviour:
- Reset: all stage-valid bits are cleared. out_valid=0, out_sig=0, out_exp=0, out_sign=0, out_frm=0, out_of=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards in-flight beats. No partial output is produced.
- Handshake:
  - A beat transfers when valid && ready.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 is loading.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready; there is no skid buffer.
  - Latency is 2 cycles; throughput is 1 beat/cycle.
  - out_* must hold stable while out_valid && !out_ready.
- Stage 1 (register lz, carry, exp_m1 = in_exp-1, data):
  - lz = leading-zero count of in_sig[SIG_BITS-1:0], range 0..SIG_BITS.
  - carry = in_sig[SIG_BITS].
- Stage 2, cases evaluated in order:
  1. carry=1: sig = in_sig >> 1, with the bit shifted out OR-ed into bit 0 (sticky). exp = in_exp+1.
  2. in_sig == 0: sig = 0, exp = 0, of = 0 (zero result; sign retained).
  3. in_exp <= 0: right shift by sh = 1-in_exp, saturating at SIG_BITS. All shifted-out bits are OR-ed into bit 0. exp = 0.
  4. in_exp - lz >= 1: left shift by lz. exp = in_exp - lz.
  5. Otherwise (subnormal clamp): left shift by in_exp-1. exp = 0.
- Overflow: if the adjusted exp >= 2^EXP_BITS-1, then out_of=1, out_exp = 2^EXP_BITS-1 and out_sig=0. Otherwise out_of=0.
- Arithmetic is done at EXP_BITS+2 signed width; truncation to EXP_BITS happens only after the overflow check.
- Sticky rule: no shifted-out 1 may ever be lost. The rounder relies on bit 0 as sticky.

Optional Feature:
- Macro: NORM_FLAGS_EN.
- When defined, adds two outputs:
  - out_zero (1 bit): case 2.
  - out_tiny (1 bit): out_exp==0 && sig!=0.
  - Both are registered with stage 2 and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fpu_pkg: default widths, and the FRM encodings RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
- Package fpu_pkg also holds the exponent max constant and a helper function for the saturating shift amount.
- Sub-module lzc: parameterised leading-zero counter (priority tree), output width clog2(SIG_BITS+1). It is instantiated in stage 1.

Test Plan (SIG_BITS=32, EXP_BITS=8; each line is stimulus -> required response):
- Leading-zero shift: in_sig=0x0_0000_0100, in_exp=100 -> two cycles later, out_sig=0x8000_0000, out_exp=77, out_of=0.
- Carry with sticky: in_sig=0x1_0000_0003, in_exp=100 -> out_sig=0x8000_0001, out_exp=101.
- Subnormal clamp and underflow:
  - in_sig=0x0_4000_0000, in_exp=1 -> out_sig=0x4000_0000, out_exp=0.
  - in_sig=0x0_8000_0001, in_exp=-2 -> out_sig=0x1000_0001, out_exp=0.
- Overflow and zero:
  - in_sig=0x1_0000_0000, in_exp=254 -> out_of=1, out_exp=255, out_sig=0.
  - in_sig=0, in_exp=50, in_sign=1 -> out_sig=0, out_exp=0, out_sign=1.
- Backpressure: stream 5 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready drops after 2 beats are buffered. No beat is lost or duplicated, order is preserved, and out_* stay stable while stalled.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0 and in_ready=1. No stale beat appears after reset releases.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default datapath widths, rounding-mode encodings,
// exponent saturation constant and the shift-amount clamp used by the
// normaliser's underflow path.
package fpu_pkg;

    localparam int SIG_BITS_D = 32;
    localparam int FRA_BITS_D = 23;
    localparam int EXP_BITS_D = 8;
    localparam int FRM_BITS_D = 3;

    typedef enum logic [FRM_BITS_D-1:0] {
        FRM_RNE = 3'b000,
        FRM_RTZ = 3'b001,
        FRM_RDN = 3'b010,
        FRM_RUP = 3'b011,
        FRM_RMM = 3'b100
    } frm_e;

    // All-ones biased exponent: infinity / overflow marker.
    function automatic int exp_max(input int exp_bits);
        return (1 << exp_bits) - 1;
    endfunction

    localparam int EXP_MAX_D = (1 << EXP_BITS_D) - 1;

    // Clamp a right-shift amount to [0, limit]; beyond the significand width
    // everything lands in sticky anyway.
    function automatic int sat_shamt(input int sh, input int limit);
        if (sh < 0)
            return 0;
        else if (sh > limit)
            return limit;
        else
            return sh;
    endfunction

endpackage

// File: rtl/fp_normalize_lzc.sv
// Parameterised leading-zero counter built as a binary priority tree.
// The input is padded below with a single 1 so an all-zero word reports
// exactly WIDTH without a separate zero detect.
module lzc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]               i_data,
    output logic [$clog2(WIDTH+1)-1:0]     o_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int P     = 1 << CNT_W;
    localparam int PADW  = P - WIDTH;

    logic [P-1:0] w_pad;

    if (PADW > 1) begin : g_pad
        assign w_pad = {i_data, 1'b1, {(PADW-1){1'b0}}};
    end else begin : g_pad1
        assign w_pad = {i_data, 1'b1};
    end

    // Level l has P>>l nodes; each node carries "has a one" and the count of
    // zeros above its first one. Higher index = more significant half.
    genvar l, n;
    for (l = 0; l <= CNT_W; l++) begin : g_lvl
        localparam int N = P >> l;
        logic [N-1:0]            v;
        logic [N-1:0][CNT_W-1:0] c;
        if (l == 0) begin : g_leaf
            assign v = w_pad;
            assign c = '0;
        end else begin : g_node
            for (n = 0; n < N; n++) begin : g_n
                assign v[n] = g_lvl[l-1].v[2*n+1] | g_lvl[l-1].v[2*n];
                assign c[n] = g_lvl[l-1].v[2*n+1] ? g_lvl[l-1].c[2*n+1]
                            : (CNT_W'(1 << (l-1)) + g_lvl[l-1].c[2*n]);
            end
        end
    end

    assign o_cnt = g_lvl[CNT_W].v[0] ? g_lvl[CNT_W].c[0] : CNT_W'(WIDTH);

endmodule

// File: rtl/fp_normalize.sv
// Two-stage significand normaliser feeding the FPU rounder.
// Stage 1 registers the leading-zero count and exponent-1; stage 2 picks
// carry / zero / underflow / normal / subnormal-clamp shift and saturates
// on exponent overflow. Bit 0 of the result is always a valid sticky.
// Optional: define NORM_FLAGS_EN to add out_zero / out_tiny outputs.
module fp_normalize
    import fpu_pkg::*;
#(
    parameter int SIG_BITS = SIG_BITS_D,
    parameter int FRA_BITS = FRA_BITS_D,
    parameter int EXP_BITS = EXP_BITS_D,
    parameter int FRM_BITS = FRM_BITS_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIG_BITS:0]     in_sig,
    input  logic [EXP_BITS+1:0]   in_exp,
    input  logic                  in_sign,
    input  logic [FRM_BITS-1:0]   in_frm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIG_BITS-1:0]   out_sig,
    output logic [EXP_BITS-1:0]   out_exp,
    output logic                  out_sign,
    output logic [FRM_BITS-1:0]   out_frm,
    output logic                  out_of
`ifdef NORM_FLAGS_EN
    ,
    output logic                  out_zero,
    output logic                  out_tiny
`endif
);

    localparam int EW  = EXP_BITS + 2;
    localparam int LZW = $clog2(SIG_BITS + 1);
    localparam logic signed [EW-1:0] ZERO   = '0;
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [EW-1:0] EMAX_S = EW'(exp_max(EXP_BITS));

    // The fraction field must sit strictly below the hidden bit.
    if (FRA_BITS + 1 > SIG_BITS) begin : g_cfg_err
        $error("fp_normalize: FRA_BITS does not fit below the hidden bit");
    end

    logic                   w_s1_load, w_s2_load;
    logic [LZW-1:0]         w_lz;

    logic                   r_s1_valid, r_s1_carry, r_s1_sign;
    logic [SIG_BITS:0]      r_s1_sig;
    logic signed [EW-1:0]   r_s1_exp, r_s1_exp_m1;
    logic [LZW-1:0]         r_s1_lz;
    logic [FRM_BITS-1:0]    r_s1_frm;

    logic [SIG_BITS-1:0]    w_lo, w_lost_mask, w_sig_n, w_sig_f;
    logic signed [EW-1:0]   w_exp_lz, w_exp_n;
    logic [LZW-1:0]         w_rsh;
    logic                   w_lost, w_of;
    logic [EXP_BITS-1:0]    w_exp_f;

    logic                   r_s2_valid, r_sign, r_of;
    logic [SIG_BITS-1:0]    r_sig;
    logic [EXP_BITS-1:0]    r_exp;
    logic [FRM_BITS-1:0]    r_frm;

    // No skid buffer: readiness ripples back combinationally from out_ready.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    lzc #(.WIDTH(SIG_BITS)) u_lzc (
        .i_data (in_sig[SIG_BITS-1:0]),
        .o_cnt  (w_lz)
    );

    // Stage 1 occupancy follows the handshake.
    always_ff @(posedge clk) begin
        if (rst)
            r_s1_valid <= 1'b0;
        else if (w_s1_load)
            r_s1_valid <= in_valid;
    end

    // Stage 1 payload: only captured on an accepted beat.
    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_sig    <= in_sig;
            r_s1_carry  <= in_sig[SIG_BITS];
            r_s1_exp    <= $signed(in_exp);
            r_s1_exp_m1 <= $signed(in_exp) - ONE;
            r_s1_lz     <= w_lz;
            r_s1_sign   <= in_sign;
            r_s1_frm    <= in_frm;
        end
    end

    // Stage 2 shift selection; cases are prioritised carry > zero > underflow
    // > normal > subnormal clamp, then overflow saturation on the result.
    always_comb begin
        w_lo        = r_s1_sig[SIG_BITS-1:0];
        w_exp_lz    = r_s1_exp - $signed({{(EW-LZW){1'b0}}, r_s1_lz});
        w_rsh       = LZW'(sat_shamt(-int'(r_s1_exp_m1), SIG_BITS));
        w_lost_mask = ~({SIG_BITS{1'b1}} << w_rsh);
        w_lost      = |(w_lo & w_lost_mask);
        w_sig_n     = '0;
        w_exp_n     = ZERO;
        if (r_s1_carry) begin
            w_sig_n = {r_s1_sig[SIG_BITS:2], |r_s1_sig[1:0]};
            w_exp_n = r_s1_exp + ONE;
        end else if (r_s1_sig == '0) begin
            w_sig_n = '0;
        end else if (r_s1_exp <= ZERO) begin
            w_sig_n = (w_lo >> w_rsh) | {{(SIG_BITS-1){1'b0}}, w_lost};
        end else if (w_exp_lz >= ONE) begin
            w_sig_n = w_lo << r_s1_lz;
            w_exp_n = w_exp_lz;
        end else begin
            w_sig_n = w_lo << r_s1_exp_m1[LZW-1:0];
        end
        w_of    = (w_exp_n >= EMAX_S);
        w_sig_f = w_of ? '0 : w_sig_n;
        w_exp_f = w_of ? EMAX_S[EXP_BITS-1:0] : w_exp_n[EXP_BITS-1:0];
    end

    // Stage 2 output register; holds while the rounder stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_sig      <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_frm      <= '0;
            r_of       <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sig  <= w_sig_f;
                r_exp  <= w_exp_f;
                r_sign <= r_s1_sign;
                r_frm  <= r_s1_frm;
                r_of   <= w_of;
            end
        end
    end

`ifdef NORM_FLAGS_EN
    logic r_zero, r_tiny;

    // Classification flags travel with the stage 2 payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_tiny <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_zero <= (r_s1_sig == '0);
            r_tiny <= (w_exp_f == '0) && (w_sig_f != '0);
        end
    end

    assign out_zero = r_zero;
    assign out_tiny = r_tiny;
`endif

    assign out_valid = r_s2_valid;
    assign out_sig   = r_sig;
    assign out_exp   = r_exp;
    assign out_sign  = r_sign;
    assign out_frm   = r_frm;
    assign out_of    = r_of;

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed corner vectors, a
// backpressure burst, randomized traffic against a value-level model,
// and a mid-stream reset.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] in_sig = '0;
    logic [9:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic [2:0]  in_frm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sig;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic [2:0]  out_frm;
    logic        out_of;
`ifdef NORM_FLAGS_EN
    logic        out_zero, out_tiny;
`endif

    fp_normalize dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sig(in_sig), .in_exp(in_exp), .in_sign(in_sign), .in_frm(in_frm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sig(out_sig), .out_exp(out_exp), .out_sign(out_sign),
        .out_frm(out_frm), .out_of(out_of)
`ifdef NORM_FLAGS_EN
        , .out_zero(out_zero), .out_tiny(out_tiny)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sig;
        logic [7:0]  exp;
        logic        of, sign, zero, tiny;
        logic [2:0]  frm;
        int          cyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [32:0] sig;
        int          e;
        logic        sign;
        logic [2:0]  frm;
        exp_t        x;
    } beat_t;

    beat_t src_q[$];
    exp_t  q[$];
    beat_t cur;
    int    n_chk = 0, n_err = 0, cyc = 0;
    bit    lat_mode = 0, saw_block = 0, stall_prev = 0;
    logic [63:0] hold;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Value-level reference: locate the leading one, decide the shift from
    // the exponent, track sticky bit by bit.
    function automatic exp_t model(input logic [32:0] s, input int e,
                                   input logic sgn, input logic [2:0] frm);
        exp_t r;
        longint m;
        int ex, p, sh;
        bit st;
        m = longint'(s); ex = 0; st = 0;
        r.zero = (m == 0);
        if (m == 0) begin
            ex = 0;
        end else if (s[32]) begin
            st = m[0]; m = m >> 1; if (st) m = m | 1; ex = e + 1;
        end else if (e <= 0) begin
            sh = (1 - e > 32) ? 32 : 1 - e;
            for (int i = 0; i < sh; i++) begin st |= m[0]; m = m >> 1; end
            if (st) m = m | 1;
            ex = 0;
        end else begin
            p = 31;
            while (m[p] == 1'b0) p--;
            if (e - (31 - p) >= 1) begin m = m << (31 - p); ex = e - (31 - p); end
            else begin m = m << (e - 1); ex = 0; end
        end
        r.of = (ex >= 255);
        if (r.of) begin ex = 255; m = 0; end
        r.sig  = m[31:0];
        r.exp  = ex[7:0];
        r.tiny = (ex == 0) && (m[31:0] != 0);
        r.sign = sgn;
        r.frm  = frm;
        r.cyc  = 0;
        r.lat  = 0;
        return r;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int k;
        b.sig = {1'b0, $urandom()};
        k = int'($urandom_range(0, 9));
        case (k)
            0:       b.sig = '0;
            1, 2:    b.sig[32] = 1'b1;
            3, 4, 5: b.sig = b.sig >> $urandom_range(1, 32);
            default: ;
        endcase
        k = int'($urandom_range(0, 3));
        case (k)
            0:       b.e = int'($urandom_range(0, 45)) - 40;
            1:       b.e = int'($urandom_range(248, 258));
            default: b.e = int'($urandom_range(1, 200));
        endcase
        b.sign = 1'($urandom_range(0, 1));
        b.frm  = 3'($urandom_range(0, 4));
        b.x    = model(b.sig, b.e, b.sign, b.frm);
        return b;
    endfunction

    task automatic observe();
        exp_t e;
        if (stall_prev)
            chk("hold_stable", {out_valid, out_sig, out_exp, out_of, out_sign, out_frm}, hold);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sig", out_sig, e.sig);
                chk("exp", out_exp, e.exp);
                chk("of", out_of, e.of);
                chk("sign", out_sign, e.sign);
                chk("frm", out_frm, e.frm);
`ifdef NORM_FLAGS_EN
                chk("zero", out_zero, e.zero);
                chk("tiny", out_tiny, e.tiny);
`endif
                if (e.lat) chk("latency", cyc - e.cyc, 2);
            end
        end
        stall_prev = out_valid && !out_ready;
        hold = {out_valid, out_sig, out_exp, out_of, out_sign, out_frm};
    endtask

    // One clock: drive at negedge, observe just after, release in_valid
    // right after the edge that took the beat.
    task automatic cycle(input bit try_send, input bit rdy);
        bit acc;
        @(negedge clk);
        cyc++;
        if (!in_valid && try_send && src_q.size() > 0) begin
            cur      = src_q.pop_front();
            in_sig   = cur.sig;
            in_exp   = 10'(cur.e);
            in_sign  = cur.sign;
            in_frm   = cur.frm;
            in_valid = 1'b1;
        end
        out_ready = rdy;
        #1;
        observe();
        acc = in_valid && in_ready;
        if (in_valid && !in_ready) saw_block = 1;
        if (acc) begin
            cur.x.cyc = cyc;
            cur.x.lat = lat_mode;
            q.push_back(cur.x);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int i;
        for (i = 0; i < budget && (src_q.size() > 0 || in_valid || q.size() > 0); i++)
            cycle(rnd ? ($urandom_range(0, 9) < 8) : 1'b1, rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
        chk(tag, q.size() + src_q.size(), 0);
    endtask

    logic [32:0] d_sig  [6] = '{33'h0_0000_0100, 33'h1_0000_0003, 33'h0_4000_0000,
                                33'h0_8000_0001, 33'h1_0000_0000, 33'h0_0000_0000};
    int          d_exp  [6] = '{100, 100, 1, -2, 254, 50};
    logic [31:0] d_osig [6] = '{32'h8000_0000, 32'h8000_0001, 32'h4000_0000,
                                32'h1000_0001, 32'h0, 32'h0};
    logic [7:0]  d_oexp [6] = '{8'd77, 8'd101, 8'd0, 8'd0, 8'd255, 8'd0};
    logic        d_of   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        d_zero [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        d_tiny [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        beat_t b;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sig", out_sig, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_out_misc", {out_of, out_sign, out_frm}, 0);
`ifdef NORM_FLAGS_EN
        chk("rst_flags", {out_zero, out_tiny}, 0);
`endif
        rst = 1'b0;

        // Directed corner vectors with fixed expected results
        lat_mode = 1;
        for (int i = 0; i < 6; i++) begin
            b.sig  = d_sig[i];
            b.e    = d_exp[i];
            b.sign = (i == 5) || (i == 1);
            b.frm  = 3'(i);
            b.x.sig = d_osig[i]; b.x.exp = d_oexp[i]; b.x.of = d_of[i];
            b.x.sign = b.sign; b.x.frm = b.frm;
            b.x.zero = d_zero[i]; b.x.tiny = d_tiny[i];
            b.x.cyc = 0; b.x.lat = 1;
            src_q.push_back(b);
        end
        drain("drain_directed", 60, 0);

        // Backpressure: 5-beat burst, downstream stalls 3 cycles mid-stream
        lat_mode = 0;
        saw_block = 0;
        for (int i = 0; i < 5; i++) src_q.push_back(rnd_beat());
        for (int i = 0; i < 40 && (src_q.size() > 0 || in_valid || q.size() > 0); i++)
            cycle(1'b1, !(i >= 3 && i < 6));
        chk("drain_burst", q.size() + src_q.size(), 0);
        chk("in_ready_blocked", saw_block, 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) src_q.push_back(rnd_beat());
        drain("drain_random", 4000, 1);

        // Reset with both stages full
        for (int i = 0; i < 2; i++) src_q.push_back(rnd_beat());
        for (int i = 0; i < 20 && (src_q.size() > 0 || in_valid); i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("full_before_rst", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        @(negedge clk); #1;
        stall_prev = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1);
            chk("post_rst_valid", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
